// File: rtl/render_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : render_sequencer_if
// Description : Bundle between the frame sequencer, its pixel-writing passes,
//               the game-over overlay source and the VGA write port.
//               slave  = the sequencer, master = everything around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface render_sequencer_if #(
    parameter int NUM_PASS = 4
);
    // Sequencing and pass pixel streams (pass k in slice k of each vector)
    logic                    frame_tick;
    logic                    over;
    logic [NUM_PASS-1:0]     pass_done;
    logic [8*NUM_PASS-1:0]   pass_x;
    logic [8*NUM_PASS-1:0]   pass_y;
    logic [3*NUM_PASS-1:0]   pass_colour;
    logic [NUM_PASS-1:0]     pass_plot;

    // Game-over overlay source
    logic [7:0]              over_x;
    logic [7:0]              over_y;
    logic [2:0]              over_colour;
    logic                    over_plot;

    // Sequencer outputs
    logic [NUM_PASS-1:0]     pass_start;
    logic [7:0]              x;
    logic [7:0]              y;
    logic [2:0]              colour;
    logic                    plot;
    logic                    busy;
    logic                    frame_drop;
    logic                    timeout;

    modport slave (
        input  frame_tick, over, pass_done, pass_x, pass_y, pass_colour,
               pass_plot, over_x, over_y, over_colour, over_plot,
        output pass_start, x, y, colour, plot, busy, frame_drop, timeout
    );

    modport master (
        output frame_tick, over, pass_done, pass_x, pass_y, pass_colour,
               pass_plot, over_x, over_y, over_colour, over_plot,
        input  pass_start, x, y, colour, plot, busy, frame_drop, timeout
    );
endinterface
`default_nettype wire

// File: rtl/render_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : render_sequencer
// Description : Frame-level scheduler for the renderer's pixel passes. Each
//               frame_tick starts the passes one at a time in fixed order,
//               waits for each done pulse and forwards the active pass's
//               pixels through one registered x/y/colour/plot port. The
//               game-over overlay preempts everything.
//               Optional per-pass watchdog: define RENDER_SEQ_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module render_sequencer #(
    parameter int NUM_PASS = 4,
    parameter int WDOG_CYC = 20000
) (
    input  wire               clk_i,
    input  wire               rst_ni,
    render_sequencer_if.slave bus
);

    localparam int KW = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
    localparam logic [KW-1:0] LAST = KW'(NUM_PASS - 1);

    if (NUM_PASS < 2 || WDOG_CYC < 2) begin : g_param_check
        $error("render_sequencer: NUM_PASS and WDOG_CYC must both be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [7:0]      x_q, x_d;
    logic [7:0]      y_q, y_d;
    logic [2:0]      colour_q, colour_d;
    logic            plot_q, plot_d;
    logic            drop_q, drop_d;

    // Per-pass views of the packed pixel buses
    logic [7:0]      px [NUM_PASS];
    logic [7:0]      py [NUM_PASS];
    logic [2:0]      pc [NUM_PASS];

    for (genvar g = 0; g < NUM_PASS; g++) begin : g_unpack
        assign px[g] = bus.pass_x[8*g +: 8];
        assign py[g] = bus.pass_y[8*g +: 8];
        assign pc[g] = bus.pass_colour[3*g +: 3];
    end

    logic done_k;
    logic wdog_hit;
    logic advance;

    // Only the active pass's done is honoured; others are ignored
    assign done_k  = bus.pass_done[k_q];
    assign advance = done_k | wdog_hit;

`ifdef RENDER_SEQ_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYC);
    logic [WW-1:0] wdog_q, wdog_d;

    assign wdog_hit    = (state_q == S_WAIT) && (wdog_q == WW'(WDOG_CYC - 1));
    // A genuine done in the expiry cycle wins and suppresses the timeout
    assign bus.timeout = wdog_hit & ~done_k & ~bus.over;

    // Watchdog counts WAIT cycles; cleared by every START
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == S_START) begin
            wdog_d = '0;
        end else if (state_q == S_WAIT && !wdog_hit) begin
            wdog_d = wdog_q + WW'(1);
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_hit    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // Next-state logic: overlay aborts the frame, otherwise step the passes
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        if (bus.over) begin
            state_d = S_IDLE;
            k_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.frame_tick) begin
                        state_d = S_START;
                        k_d     = '0;
                    end
                end
                S_START: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (advance) begin
                        if (k_q == LAST) begin
                            state_d = S_IDLE;
                            k_d     = '0;
                        end else begin
                            state_d = S_START;
                            k_d     = k_q + KW'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    k_d     = '0;
                end
            endcase
        end
    end

    // One-hot start pulse for the pass being launched
    always_comb begin
        bus.pass_start = '0;
        if (state_q == S_START) begin
            bus.pass_start[k_q] = 1'b1;
        end
    end

    // Pixel mux: overlay first, then the active pass; coordinates hold otherwise
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        if (bus.over) begin
            x_d      = bus.over_x;
            y_d      = bus.over_y;
            colour_d = bus.over_colour;
            plot_d   = bus.over_plot;
        end else if (state_q == S_WAIT) begin
            x_d      = px[k_q];
            y_d      = py[k_q];
            colour_d = pc[k_q];
            plot_d   = bus.pass_plot[k_q];
        end
    end

    // A tick that arrives mid-frame is reported, not acted on (silent under over)
    assign drop_d = bus.frame_tick & ~bus.over & (state_q != S_IDLE);

    // State, pass index and registered VGA port
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.colour     = colour_q;
    assign bus.plot       = plot_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.frame_drop = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_render_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_render_sequencer
// Description : Scoreboard bench for render_sequencer. Emulated passes answer
//               each start with a done pulse; every stimulus pushes the
//               outputs it should cause, popped on the cycle they are due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_render_sequencer;

    localparam int NUM_PASS = 4;
    localparam int WDOG_CYC = 50;
    localparam int LAT      = 10;

    localparam int K_START = 0;
    localparam int K_PIX   = 1;
    localparam int K_DROP  = 2;
    localparam int K_TOUT  = 3;
    localparam int K_BUSY  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    render_sequencer_if #(.NUM_PASS(NUM_PASS)) bus ();

    render_sequencer #(
        .NUM_PASS (NUM_PASS),
        .WDOG_CYC (WDOG_CYC)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        int cyc;
        int kind;
        int val;
    } exp_t;

    exp_t sb[$];
    int   now       = 0;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   done_at   [NUM_PASS];
    int   done_lat  [NUM_PASS];
    int   start_cyc [NUM_PASS];
    int   t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, now);
        end
    endtask

    task automatic push(input int cyc, input int kind, input int val);
        sb.push_back('{cyc, kind, val});
    endtask

    function automatic logic [31:0] pix_now();
        return {12'd0, bus.plot, bus.colour, bus.y, bus.x};
    endfunction

    task automatic cancel_passes();
        for (int k = 0; k < NUM_PASS; k++) done_at[k] = -1;
        bus.pass_done = '0;
    endtask

    // One clock: compare due expectations, then let the emulated passes respond
    task automatic step();
        bit seen_start;
        bit seen_drop;
        bit seen_tout;
        seen_start = 1'b0;
        seen_drop  = 1'b0;
        seen_tout  = 1'b0;
        @(posedge clk);
        #1;
        now++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == now) begin
                case (sb[i].kind)
                    K_START: begin check_eq("pass_start", 32'(bus.pass_start), sb[i].val); seen_start = 1'b1; end
                    K_PIX:   check_eq("pixel", pix_now(), sb[i].val);
                    K_DROP:  begin check_eq("frame_drop", 32'(bus.frame_drop), sb[i].val); seen_drop = 1'b1; end
                    K_TOUT:  begin check_eq("timeout", 32'(bus.timeout), sb[i].val); seen_tout = 1'b1; end
                    default: check_eq("busy", 32'(bus.busy), sb[i].val);
                endcase
                sb.delete(i);
            end
        end
        if (!seen_start && bus.pass_start != '0) check_eq("start_unexp", 32'(bus.pass_start), 0);
        if (!seen_drop && bus.frame_drop != 1'b0) check_eq("drop_unexp", 32'(bus.frame_drop), 0);
        if (!seen_tout && bus.timeout != 1'b0) check_eq("tout_unexp", 32'(bus.timeout), 0);

        bus.pass_done = '0;
        for (int k = 0; k < NUM_PASS; k++) begin
            if (bus.pass_start[k] === 1'b1) begin
                start_cyc[k] = now;
                if (done_lat[k] >= 0) done_at[k] = now + done_lat[k] + 1;
            end
        end
        for (int k = 0; k < NUM_PASS; k++) begin
            if (done_at[k] == now) begin
                bus.pass_done[k] = 1'b1;
                done_at[k] = -1;
                if (k < NUM_PASS - 1) push(now + 1, K_START, 1 << (k + 1));
                else                  push(now + 1, K_BUSY, 0);
            end
        end
    endtask

    task automatic run_to(input int c);
        while (now < c) step();
    endtask

    task automatic tick_start();
        t = now;
        bus.frame_tick = 1'b1;
        push(t + 1, K_START, 1);
        push(t + 1, K_BUSY, 1);
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},  32'(bus.busy), 0);
        check_eq({tag, "_start"}, 32'(bus.pass_start), 0);
        check_eq({tag, "_pix"},   pix_now(), 0);
        check_eq({tag, "_drop"},  32'(bus.frame_drop), 0);
        check_eq({tag, "_tout"},  32'(bus.timeout), 0);
    endtask

    initial begin
        bus.frame_tick  = 1'b0;
        bus.over        = 1'b0;
        bus.pass_done   = '0;
        bus.pass_x      = '0;
        bus.pass_y      = '0;
        bus.pass_colour = '0;
        bus.pass_plot   = '0;
        bus.over_x      = '0;
        bus.over_y      = '0;
        bus.over_colour = '0;
        bus.over_plot   = 1'b0;
        for (int k = 0; k < NUM_PASS; k++) begin
            done_at[k]   = -1;
            done_lat[k]  = LAT;
            start_cyc[k] = -1;
        end

        // Reset state
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) step();

        // Basic sequence: 1,2,4,8 twelve cycles apart, busy for 48 cycles
        tick_start();
        push(t + 48, K_BUSY, 1);
        push(t + 49, K_BUSY, 0);
        run_to(t + 55);
        check_eq("spacing01", start_cyc[1] - start_cyc[0], 12);
        check_eq("spacing12", start_cyc[2] - start_cyc[1], 12);
        check_eq("spacing23", start_cyc[3] - start_cyc[2], 12);

        // Frame drop during pass 1, pixel forwarding during pass 2
        tick_start();
        run_to(t + 16);
        bus.frame_tick = 1'b1;
        push(t + 17, K_DROP, 1);
        push(t + 17, K_BUSY, 1);
        step();
        bus.frame_tick = 1'b0;
        run_to(t + 28);
        bus.pass_x[23:16] = 8'h40;  bus.pass_y[23:16] = 8'h21;  bus.pass_colour[8:6] = 3'b010;
        bus.pass_x[15:8]  = 8'h11;  bus.pass_y[15:8]  = 8'h22;  bus.pass_colour[5:3] = 3'b111;
        bus.pass_plot = 4'b0110;
        push(t + 29, K_PIX, {12'd0, 1'b1, 3'b010, 8'h21, 8'h40});
        step();
        bus.pass_x[15:8] = 8'h55;
        bus.pass_plot = 4'b0010;
        push(t + 30, K_PIX, {12'd0, 1'b0, 3'b010, 8'h21, 8'h40});
        step();
        bus.pass_plot = '0;
        push(t + 31, K_PIX, {12'd0, 1'b0, 3'b010, 8'h21, 8'h40});
        run_to(t + 55);
        check_eq("drop_frame_starts", start_cyc[3] - start_cyc[0], 36);

        // Game-over preemption mid pass 2
        tick_start();
        run_to(t + 30);
        cancel_passes();
        bus.over = 1'b1;
        bus.over_x = 8'h7A;  bus.over_y = 8'h33;  bus.over_colour = 3'b101;  bus.over_plot = 1'b1;
        bus.pass_x[23:16] = 8'h66;  bus.pass_plot = 4'b0100;
        push(t + 31, K_BUSY, 0);
        push(t + 31, K_PIX, {12'd0, 1'b1, 3'b101, 8'h33, 8'h7A});
        step();
        bus.over_x = 8'h01;  bus.over_plot = 1'b0;
        bus.frame_tick = 1'b1;
        push(t + 32, K_PIX, {12'd0, 1'b0, 3'b101, 8'h33, 8'h01});
        push(t + 32, K_BUSY, 0);
        step();
        bus.frame_tick = 1'b0;
        bus.pass_plot = '0;
        push(t + 40, K_BUSY, 0);
        run_to(t + 50);
        bus.over = 1'b0;
        repeat (3) step();

        // Asynchronous reset during pass 1 WAIT
        tick_start();
        run_to(t + 18);
        #5;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        cancel_passes();
        sb.delete();
        repeat (2) step();
        #5;
        rst_n = 1'b1;
        step();
        tick_start();
        push(t + 49, K_BUSY, 0);
        run_to(t + 55);
        check_eq("post_rst_frame", start_cyc[3] - start_cyc[0], 36);

`ifdef RENDER_SEQ_WATCHDOG_EN
        // Pass 0 never finishes: watchdog forces it after 50 WAIT cycles
        done_lat[0] = -1;
        tick_start();
        push(t + 51, K_TOUT, 1);
        push(t + 52, K_START, 2);
        push(t + 87, K_BUSY, 1);
        run_to(t + 95);
        done_lat[0] = LAT;
`else
        // Pass 0 never finishes: without a watchdog the frame never ends
        done_lat[0] = -1;
        tick_start();
        push(t + 200, K_BUSY, 1);
        run_to(t + 205);
        #5;
        rst_n = 1'b0;
        #1;
        check_all_zero("wdog_off_rst");
        cancel_passes();
        step();
        rst_n = 1'b1;
        step();
        done_lat[0] = LAT;
`endif

        check_eq("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
